regincr_out_queue: RTL and testbench
====================================

# regincr_out_queue

Output buffer that sits directly downstream of the register-incrementer stage and captures its 8-bit results into a small FIFO for a consumer with valid/ready flow control. The incrementer cannot be stalled, so the queue accepts a word whenever it has space and counts every offered word it had to drop. Storage is a circular buffer with registered head/tail pointers. Deq data comes straight from the head entry, with no enq-to-deq bypass.

## Interface
- p_nbits, 8, message width in bits
- p_num_entries, 4, queue depth; power of two, ≥ 2
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; reset=0 clears state immediately
- enq_val  input  1  upstream word valid this cycle
- enq_msg  input  p_nbits  upstream word (incrementer output)
- enq_rdy  output  1  queue can accept a word this cycle
- deq_val  output  1  head entry valid
- deq_msg  output  p_nbits  head entry data
- deq_rdy  input  1  consumer takes head this cycle
- num_free  output  clog2(p_num_entries)+1  empty slots remaining
- drop_count  output  8  saturating count of words offered while full

## Operation
- State: storage array of p_num_entries × p_nbits, head pointer, tail pointer, count (0..p_num_entries), drop_count.
- enq fire = enq_val && enq_rdy. On fire, write enq_msg to storage[tail] and increment tail mod p_num_entries.
- deq fire = deq_val && deq_rdy. On fire, increment head mod p_num_entries.
- Count update:
  - +1 on enq fire only
  - −1 on deq fire only
  - unchanged when both fire or neither fires
- enq_rdy = (count != p_num_entries). enq_rdy depends only on registered count, not on deq_rdy. A full queue refuses enq even when a deq fires in the same cycle.
- deq_val = (count != 0).
- deq_msg = storage[head] when deq_val=1; forced to 0 when empty.
- num_free = p_num_entries − count.
- Drop: enq_val=1 && enq_rdy=0 at a clock edge increments drop_count. drop_count saturates at 255 and is cleared only by reset.
- Pointer wrap: pointers are clog2(p_num_entries) bits and wrap naturally from p_num_entries−1 to 0. Full and empty are distinguished by count, never by pointer equality.
- Storage contents are not reset. Outputs never expose unreset storage, because of the deq_msg gating.

## Timing
- Reset (reset=0, asynchronous) gives:
  - count=0, head=0, tail=0, drop_count=0
  - deq_val=0, deq_msg=0, enq_rdy=1
  - num_free=p_num_entries
- Deassertion of reset takes effect at the next rising edge. No enq is accepted on an edge while reset=0.
- Latency: a word enqueued at edge k appears on deq_msg with deq_val=1 after edge k, i.e. the following cycle. There is no same-cycle bypass.
- Throughput: one enq and one deq per cycle, sustained, when 0 < count < p_num_entries.
- Order is strictly FIFO.
- Empty, simultaneous enq_val and deq_rdy: enq fires, deq does not; count becomes 1.
- Full, simultaneous enq_val and deq_rdy: deq fires, enq is dropped (drop_count+1); count becomes p_num_entries−1.
- Reset asserted mid-operation: all queued words are discarded immediately and drop_count clears. Outputs go to their reset values without waiting for a clock edge.
- All outputs are functions of registered state only; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** hold reset=0 for 2 cycles, then release -> enq_rdy=1, deq_val=0, deq_msg=0, num_free=4, drop_count=0.
- **Basic FIFO latency:**
  - stimulus: enq 8'h01, 8'h14, 8'h28 on consecutive edges with deq_rdy=0; then deq_rdy=1
  - response: deq_val rises the cycle after the first enq; num_free reaches 1; deq_msg yields 01, 14, 28 in order; deq_val=0 afterwards
- **Full and drop:**
  - stimulus: enq 5 words (0x10..0x14) with deq_rdy=0
  - response: enq_rdy=0 after the 4th; drop_count=1; dequeued words are 0x10..0x13 only
- **Full with simultaneous enq+deq:**
  - stimulus: full queue holding A0..A3, enq_val=1 with 0x55, deq_rdy=1 for one cycle
  - response: A0 leaves, 0x55 dropped, num_free=1, drop_count+1
- **Wrap-around streaming:**
  - stimulus: 20 words 0x00..0x13 with enq_val=1 and deq_rdy=1 every cycle after the first
  - response: all 20 words out in order, count stays at 1, drop_count=0
- **Async reset mid-stream and saturation:**
  - stimulus: pull reset=0 between edges with 3 words queued
  - response: deq_val=0 and num_free=4 before the next edge
  - stimulus: then hold the queue full while offering 300 words
  - response: drop_count=255

Source files
------------

// File: rtl/regincr_out_queue_if.sv
// Bundle of queue-side signals between the incrementer output buffer and
// its producer/consumer. The queue uses the slave view; the traffic
// source/sink uses the master view.
interface regincr_out_queue_if #(
   parameter int p_nbits       = 8,
   parameter int p_num_entries = 4
);
   logic                              enq_val;
   logic [p_nbits-1:0]                enq_msg;
   logic                              enq_rdy;
   logic                              deq_val;
   logic [p_nbits-1:0]                deq_msg;
   logic                              deq_rdy;
   logic [$clog2(p_num_entries):0]    num_free;
   logic [7:0]                        drop_count;

   modport master (
      output enq_val, enq_msg, deq_rdy,
      input  enq_rdy, deq_val, deq_msg, num_free, drop_count
   );

   modport slave (
      input  enq_val, enq_msg, deq_rdy,
      output enq_rdy, deq_val, deq_msg, num_free, drop_count
   );
endinterface

// File: rtl/regincr_out_queue.sv
// Output buffer for the register-incrementer stage. A circular buffer with
// registered head/tail pointers and an occupancy count. The incrementer
// cannot stall, so words offered while full are dropped and counted
// (saturating at 255). All outputs derive from registered state only.
module regincr_out_queue #(
   parameter int p_nbits       = 8,
   parameter int p_num_entries = 4
) (
   input  logic                   clk,
   input  logic                   reset,   // asynchronous, active-low
   regincr_out_queue_if.slave     q
);

   localparam int PW = $clog2(p_num_entries);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(p_num_entries);

   logic [p_nbits-1:0] mem_q [p_num_entries];
   logic [PW-1:0]      head_q, head_d;
   logic [PW-1:0]      tail_q, tail_d;
   logic [CW-1:0]      count_q, count_d;
   logic [7:0]         drop_q, drop_d;

   logic enq_fire;
   logic deq_fire;

   // Outputs decoded from registered state; head data is gated so unwritten
   // storage never leaks out while the queue is empty.
   always_comb begin
      q.enq_rdy    = (count_q != FULL_COUNT);
      q.deq_val    = (count_q != '0);
      q.deq_msg    = q.deq_val ? mem_q[head_q] : '0;
      q.num_free   = FULL_COUNT - count_q;
      q.drop_count = drop_q;
   end

   // Next-state for pointers, occupancy and the drop counter.
   always_comb begin
      enq_fire = q.enq_val && q.enq_rdy;
      deq_fire = q.deq_val && q.deq_rdy;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      drop_d   = drop_q;
      if (enq_fire) tail_d = tail_q + PW'(1);
      if (deq_fire) head_d = head_q + PW'(1);
      if (enq_fire && !deq_fire)      count_d = count_q + CW'(1);
      else if (deq_fire && !enq_fire) count_d = count_q - CW'(1);
      if (q.enq_val && !q.enq_rdy && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   // Control state register with asynchronous clear.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         drop_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         drop_q  <= drop_d;
      end
   end

   // Storage write at the tail on an accepted word.
   // NOTE: the data array is deliberately left out of reset; occupancy
   // tracking plus output gating makes its contents unobservable until written.
   always_ff @(posedge clk) begin
      if (enq_fire && reset) mem_q[tail_q] <= q.enq_msg;
   end

endmodule

// File: tb/tb_regincr_out_queue.sv
// Directed bench for regincr_out_queue with a scoreboard queue of expected
// words and a small occupancy/drop model.
module tb_regincr_out_queue;

   logic clk;
   logic reset;

   regincr_out_queue_if #(.p_nbits(8), .p_num_entries(4)) qif ();

   regincr_out_queue #(.p_nbits(8), .p_num_entries(4)) dut (
      .clk   (clk),
      .reset (reset),
      .q     (qif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] sb [$];
   int         m_drop = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs, compare outputs against the model, update the
   // model with the fires that the coming edge should perform, take the edge.
   task automatic step(input logic en, input logic [7:0] msg, input logic dr);
      int  cnt;
      bit  enq_ok, deq_ok;
      qif.enq_val = en;
      qif.enq_msg = msg;
      qif.deq_rdy = dr;
      #1;
      cnt = sb.size();
      check("enq_rdy",    32'(qif.enq_rdy),    32'(cnt != 4));
      check("deq_val",    32'(qif.deq_val),    32'(cnt != 0));
      check("num_free",   32'(qif.num_free),   32'(4 - cnt));
      check("drop_count", 32'(qif.drop_count), 32'(m_drop));
      if (cnt != 0) check("deq_msg", 32'(qif.deq_msg), 32'(sb[0]));
      else          check("deq_msg_empty", 32'(qif.deq_msg), 32'h0);
      enq_ok = en && (cnt != 4);
      deq_ok = dr && (cnt != 0);
      if (deq_ok) void'(sb.pop_front());
      if (enq_ok) sb.push_back(msg);
      if (en && !enq_ok && m_drop != 255) m_drop++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && sb.size() != 0; i++) step(1'b0, 8'h00, 1'b1);
      check("drained", 32'(sb.size()), 32'h0);
      step(1'b0, 8'h00, 1'b0);
   endtask

   // Assert reset between edges and check outputs react before any edge.
   task automatic async_reset(input int hold_cycles);
      reset = 1'b0;
      qif.enq_val = 1'b0;
      qif.deq_rdy = 1'b0;
      #1;
      check("rst_deq_val",  32'(qif.deq_val),    32'h0);
      check("rst_num_free", 32'(qif.num_free),   32'h4);
      check("rst_drop",     32'(qif.drop_count), 32'h0);
      check("rst_enq_rdy",  32'(qif.enq_rdy),    32'h1);
      check("rst_deq_msg",  32'(qif.deq_msg),    32'h0);
      sb.delete();
      m_drop = 0;
      repeat (hold_cycles) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset       = 1'b0;
      qif.enq_val = 1'b0;
      qif.enq_msg = 8'h00;
      qif.deq_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("reset_enq_rdy",  32'(qif.enq_rdy),    32'h1);
      check("reset_deq_val",  32'(qif.deq_val),    32'h0);
      check("reset_deq_msg",  32'(qif.deq_msg),    32'h0);
      check("reset_num_free", 32'(qif.num_free),   32'h4);
      check("reset_drop",     32'(qif.drop_count), 32'h0);

      // Basic FIFO latency and order.
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h14, 1'b0);
      step(1'b1, 8'h28, 1'b0);
      check("basic_free1", 32'(qif.num_free), 32'h1);
      drain();

      // Full and drop: fifth word is refused.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
      check("full_enq_rdy", 32'(qif.enq_rdy),    32'h0);
      check("full_drop",    32'(qif.drop_count), 32'h1);
      drain();

      // Full with simultaneous enq and deq: deq fires, enq dropped.
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
      step(1'b1, 8'h55, 1'b1);
      check("fsim_free", 32'(qif.num_free),   32'h1);
      check("fsim_drop", 32'(qif.drop_count), 32'h2);
      check("fsim_head", 32'(qif.deq_msg),    32'hA1);
      drain();

      // Wrap-around streaming from a clean reset.
      async_reset(1);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 8'(i), i > 0);
         check("stream_count", 32'(qif.num_free), 32'h3);
      end
      drain();
      check("stream_drop", 32'(qif.drop_count), 32'h0);

      // Asynchronous reset with three words queued.
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
      async_reset(2);
      step(1'b0, 8'h00, 1'b0);

      // Saturation of the drop counter.
      for (int i = 0; i < 304; i++) step(1'b1, 8'(i), 1'b0);
      check("sat_drop", 32'(qif.drop_count), 32'd255);
      check("sat_full", 32'(qif.num_free),   32'h0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
